// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback path: address/word widths and the
// registered write bundle that drives the single register-file write port.
package regfile_wb_arbiter_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_WORD_LEN   = 32;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_WORD_LEN-1:0]   rf_word_t;

  typedef struct packed {
    logic     wen;
    rf_addr_t waddr;
    rf_word_t wdata;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid at or after the pointer, 0-cycle latency.
// Grant depends only on requests and the pointer; the pointer moves past the winner on every grant.
module regfile_wb_arbiter_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int PW = (N_REQ > 2) ? 2 : 1;

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i >= int'(rr_q))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_idx  = PW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_idx  = PW'(i);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (found) begin
      rr_d = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N_REQ writeback requesters (1-cycle registered write)
// and tracks per-register busy state for decode hazards; losers stall until their ready.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int WORD_LEN   = RF_WORD_LEN,
  parameter int N_REQ      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_waddr,
  input  logic [N_REQ*WORD_LEN-1:0] req_wdata,
  output logic                      rf_wen,
  output logic [ADDR_WIDTH-1:0]     rf_waddr,
  output logic [WORD_LEN-1:0]       rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_WIDTH-1:0]     issue_rd,
  output logic                      issue_ready,
  input  logic [ADDR_WIDTH-1:0]     chk_raddr1,
  input  logic [ADDR_WIDTH-1:0]     chk_raddr2,
  output logic                      hazard,
  output logic [2**ADDR_WIDTH-1:0]  busy_vec
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [N_REQ-1:0]      gnt;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_LEN-1:0]   sel_data;
  rf_wr_t                wr_q, wr_d;
  logic [NREG-1:0]       busy_q, busy_d;

  regfile_wb_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (req_valid),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = sel_data | req_wdata[i*WORD_LEN +: WORD_LEN];
      end
    end
  end

  // x0 writes are accepted but swallowed; address/data hold when no write is emitted.
  always_comb begin
    wr_d     = wr_q;
    wr_d.wen = hs && (sel_addr != '0);
    if (wr_d.wen) begin
      wr_d.waddr = rf_addr_t'(sel_addr);
      wr_d.wdata = rf_word_t'(sel_data);
    end
  end

  assign rf_wen   = wr_q.wen;
  assign rf_waddr = ADDR_WIDTH'(wr_q.waddr);
  assign rf_wdata = WORD_LEN'(wr_q.wdata);

  assign issue_ready = !busy_q[issue_rd] || (issue_rd == '0);
  assign hazard      = busy_q[chk_raddr1] | busy_q[chk_raddr2];
  assign busy_vec    = busy_q;

  // Clear lands on the same edge the register file latches; a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_q.wen) begin
      busy_d[rf_waddr] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q   <= '0;
      busy_q <= '0;
    end else begin
      wr_q   <= wr_d;
      busy_q <= busy_d;
    end
  end

endmodule
